// File: rtl/aacc32_stream_if.sv
// Stream bundle for aacc32_stream: operand beats in, one accumulated result per vector out.
// Both directions use valid/ready: a transfer happens on a rising clk where valid && ready; once raised, valid and its payload hold until that transfer.
interface aacc32_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_exact;
    logic [31:0] out_approx;
    logic [31:0] out_err_max;
    logic [15:0] out_count;
    logic        out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_exact, out_approx, out_err_max, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_exact, out_approx, out_err_max, out_count, out_ovf
    );
endinterface

// File: rtl/aacc32_stream.sv
// Exact vs DROP-truncated approximate running sums with worst-case divergence, one result per vector.
// Build option AACC_SAT_EN: accumulators saturate on overflow instead of wrapping.
module aacc32_stream #(
    parameter int DROP    = 0,
    parameter int MAX_LEN = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    aacc32_stream_if.slave bus,
    output logic           dbg_hold
);
    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;
    state_t state, state_nx;

    logic signed [31:0] acc_exact, acc_approx, d;
    logic signed [31:0] exact_w, approx_w, exact_n, approx_n;
    logic [31:0] err_max, err_n, abs_c;
    logic [32:0] diff, abs_d;
    logic [15:0] count, count_n;
    logic        ovf, ovf_n, ex_ovf, ap_ovf;
    logic        take, done, end_vec;

    assign take = bus.in_valid && bus.in_ready;
    assign done = bus.out_valid && bus.out_ready;

    always_comb begin
        d        = bus.in_data;
        exact_w  = acc_exact + d;
        approx_w = ((acc_approx >>> DROP) + (d >>> DROP)) << DROP;
        // Same-sign operands with a result of the other sign means the add left the 32-bit range.
        ex_ovf   = (acc_exact[31] == d[31]) && (exact_w[31] != d[31]);
        ap_ovf   = (acc_approx[31] == d[31]) && (approx_w[31] != d[31]);
`ifdef AACC_SAT_EN
        exact_n  = ex_ovf ? (d[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : exact_w;
        approx_n = ap_ovf ? (d[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : approx_w;
`else
        exact_n  = exact_w;
        approx_n = approx_w;
`endif
        diff     = {exact_n[31], exact_n} - {approx_n[31], approx_n};
        abs_d    = diff[32] ? (33'd0 - diff) : diff;
        abs_c    = abs_d[32] ? 32'hFFFF_FFFF : abs_d[31:0];
        err_n    = (abs_c > err_max) ? abs_c : err_max;
        count_n  = count + 16'd1;
        ovf_n    = ovf | ex_ovf | ap_ovf;
        end_vec  = bus.in_last || (count_n == 16'(MAX_LEN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACC:     if (take && end_vec) state_nx = HOLD;
            HOLD:    if (done) state_nx = ACC;
            default: state_nx = ACC;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACC);
        bus.out_valid = (state == HOLD);
        dbg_hold      = (state == HOLD);
    end

    // Result registers only change on the closing beat, so they stay put through HOLD and after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_exact       <= '0;
            acc_approx      <= '0;
            err_max         <= '0;
            count           <= '0;
            ovf             <= 1'b0;
            bus.out_exact   <= '0;
            bus.out_approx  <= '0;
            bus.out_err_max <= '0;
            bus.out_count   <= '0;
            bus.out_ovf     <= 1'b0;
        end else if (take) begin
            acc_exact  <= exact_n;
            acc_approx <= approx_n;
            err_max    <= err_n;
            count      <= count_n;
            ovf        <= ovf_n;
            if (end_vec) begin
                bus.out_exact   <= exact_n;
                bus.out_approx  <= approx_n;
                bus.out_err_max <= err_n;
                bus.out_count   <= count_n;
                bus.out_ovf     <= ovf_n;
            end
        end else if (done) begin
            acc_exact  <= '0;
            acc_approx <= '0;
            err_max    <= '0;
            count      <= '0;
            ovf        <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aacc32_stream.sv
// Bench for aacc32_stream: three instances (DROP=0, DROP=2, MAX_LEN=4) driven by directed and random vectors.
// Expected results come from hand constants or from a wide-arithmetic model of the accumulation rules.
module tb_aacc32_stream;
    localparam int W = 113;

    logic clk, rst_n;
    logic [2:0] iv, ilast, ordy, irdy, ovld, oovf, dhold;
    logic [2:0][31:0] idata, oex, oap, oerr;
    logic [2:0][15:0] ocnt;
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] vq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aacc32_stream_if bus ();
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = idata[g];
        assign bus.in_last   = ilast[g];
        assign bus.out_ready = ordy[g];
        assign irdy[g] = bus.in_ready;
        assign ovld[g] = bus.out_valid;
        assign oex[g]  = bus.out_exact;
        assign oap[g]  = bus.out_approx;
        assign oerr[g] = bus.out_err_max;
        assign ocnt[g] = bus.out_count;
        assign oovf[g] = bus.out_ovf;
        aacc32_stream #(.DROP(g == 1 ? 2 : 0), .MAX_LEN(g == 2 ? 4 : 256)) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_hold(dhold[g])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] pk(input logic [31:0] e, input logic [31:0] a,
                                        input logic [31:0] m, input logic [15:0] c, input logic o);
        return {e, a, m, c, o};
    endfunction

    function automatic longint fit(input longint v, output bit o);
        o = 1'b0;
        if (v > 64'sd2147483647) begin
            o = 1'b1;
`ifdef AACC_SAT_EN
            v = 64'sd2147483647;
`else
            v = v - 64'sd4294967296;
`endif
        end else if (v < -64'sd2147483648) begin
            o = 1'b1;
`ifdef AACC_SAT_EN
            v = -64'sd2147483648;
`else
            v = v + 64'sd4294967296;
`endif
        end
        return v;
    endfunction

    // Reference: mathematical sums range-checked into 32 bits; approx uses floor division by 2^drop.
    function automatic logic [W-1:0] model(input int drop);
        longint ex, ap, em, d, df;
        bit o1, o2, ov;
        ex = 0; ap = 0; em = 0; ov = 1'b0;
        foreach (vq[i]) begin
            d  = longint'($signed(vq[i]));
            ex = fit(ex + d, o1);
            ap = fit(((ap >>> drop) + (d >>> drop)) * (64'sd1 <<< drop), o2);
            ov = ov | o1 | o2;
            df = (ex >= ap) ? ex - ap : ap - ex;
            if (df > 64'sd4294967295) df = 64'sd4294967295;
            if (df > em) em = df;
        end
        return pk(ex[31:0], ap[31:0], em[31:0], 16'(vq.size()), ov);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input int sel, input string tag, input logic [W-1:0] e);
        chk({tag, ".exact"},   oex[sel],  e[112:81]);
        chk({tag, ".approx"},  oap[sel],  e[80:49]);
        chk({tag, ".err_max"}, oerr[sel], e[48:17]);
        chk({tag, ".count"},   32'(ocnt[sel]), 32'(e[16:1]));
        chk({tag, ".ovf"},     32'(oovf[sel]), 32'(e[0]));
    endtask

    task automatic chk_zero(input int sel, input string tag);
        chk({tag, ".out_valid"}, 32'(ovld[sel]), 32'd0);
        chk({tag, ".in_ready"},  32'(irdy[sel]), 32'd1);
        chk({tag, ".dbg_hold"},  32'(dhold[sel]), 32'd0);
        chk_fields(sel, tag, '0);
    endtask

    // Starts and ends on a falling edge; beats of vq go out with optional idle gaps.
    task automatic send_vector(input int sel, input bit last_final, input bit expect_done, input string tag);
        int n;
        n = vq.size();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                iv[sel] = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            chk({tag, ".beat_ready"}, 32'(irdy[sel]), 32'd1);
            chk({tag, ".beat_no_valid"}, 32'(ovld[sel]), 32'd0);
            iv[sel]    = 1'b1;
            idata[sel] = vq[i];
            ilast[sel] = (i == n - 1) && last_final;
            @(posedge clk);
            @(negedge clk);
        end
        iv[sel]    = 1'b0;
        ilast[sel] = 1'b0;
        chk({tag, ".latency"}, 32'(ovld[sel]), expect_done ? 32'd1 : 32'd0);
    endtask

    task automatic recv(input int sel, input string tag);
        logic [W-1:0] e;
        int hold;
        e = exp_q.pop_front();
        for (int t = 0; t < 20 && ovld[sel] !== 1'b1; t++) @(negedge clk);
        hold = $urandom_range(0, 3);
        for (int k = 0; k <= hold; k++) begin
            chk({tag, ".out_valid"}, 32'(ovld[sel]), 32'd1);
            chk({tag, ".in_ready_low"}, 32'(irdy[sel]), 32'd0);
            chk({tag, ".dbg_hold"}, 32'(dhold[sel]), 32'd1);
            chk_fields(sel, tag, e);
            if (k < hold) @(negedge clk);
        end
        ordy[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[sel] = 1'b0;
        chk({tag, ".released"}, 32'(ovld[sel]), 32'd0);
        chk({tag, ".ready_back"}, 32'(irdy[sel]), 32'd1);
        chk({tag, ".kept_exact"}, oex[sel], e[112:81]);
    endtask

    task automatic async_reset(input int sel, input string tag);
        #2 rst_n = 1'b0;
        #1 chk_zero(sel, tag);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk({tag, ".ready_after"}, 32'(irdy[sel]), 32'd1);
    endtask

    initial begin
        int sel, len;
        logic lastf;
        rst_n = 1'b0;
        iv = '0; ilast = '0; ordy = '0; idata = '0;
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk_zero(s, "reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk_zero(s, "after_reset");

        vq = '{32'd5, 32'hFFFF_FFFD, 32'd10};
        exp_q.push_back(pk(32'd12, 32'd12, 32'd0, 16'd3, 1'b0));
        send_vector(0, 1'b1, 1'b1, "drop0");
        recv(0, "drop0");

        vq = '{32'd5, 32'd7};
        exp_q.push_back(pk(32'd12, 32'd8, 32'd4, 16'd2, 1'b0));
        send_vector(1, 1'b1, 1'b1, "drop2_a");
        recv(1, "drop2_a");

        vq = '{32'd3, 32'd3, 32'd3};
        exp_q.push_back(pk(32'd9, 32'd0, 32'd9, 16'd3, 1'b0));
        send_vector(1, 1'b1, 1'b1, "drop2_b");
        recv(1, "drop2_b");

        vq = '{32'd1, 32'd1, 32'd1, 32'd1};
        exp_q.push_back(pk(32'd4, 32'd4, 32'd0, 16'd4, 1'b0));
        send_vector(2, 1'b0, 1'b1, "maxlen");
        iv[2] = 1'b1;
        idata[2] = 32'd1;
        for (int k = 0; k < 5; k++) begin
            chk("maxlen_hold.in_ready", 32'(irdy[2]), 32'd0);
            chk("maxlen_hold.out_valid", 32'(ovld[2]), 32'd1);
            chk("maxlen_hold.count", 32'(ocnt[2]), 32'd4);
            chk("maxlen_hold.exact", oex[2], 32'd4);
            @(negedge clk);
        end
        iv[2] = 1'b0;
        recv(2, "maxlen");

        vq = '{32'h7FFF_FFFF, 32'd1};
`ifdef AACC_SAT_EN
        exp_q.push_back(pk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 16'd2, 1'b1));
`else
        exp_q.push_back(pk(32'h8000_0000, 32'h8000_0000, 32'd0, 16'd2, 1'b1));
`endif
        send_vector(0, 1'b1, 1'b1, "ovf");
        recv(0, "ovf");

        vq = '{32'd2, 32'd3};
        exp_q.push_back(pk(32'd5, 32'd5, 32'd0, 16'd2, 1'b0));
        send_vector(0, 1'b1, 1'b1, "ovf_clear");
        recv(0, "ovf_clear");

        repeat (36) begin
            sel = $urandom_range(0, 2);
            len = $urandom_range(1, (sel == 2) ? 4 : 6);
            lastf = (len < 4 || sel != 2) ? 1'b1 : 1'($urandom_range(0, 1));
            vq.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       vq.push_back($urandom);
                    1:       vq.push_back(32'($urandom_range(0, 40)) - 32'd20);
                    2:       vq.push_back(32'h7000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF)));
                    default: vq.push_back(32'h8000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF)));
                endcase
            end
            exp_q.push_back(model((sel == 1) ? 2 : 0));
            send_vector(sel, lastf, 1'b1, "rand");
            recv(sel, "rand");
        end

        vq = '{32'd9, 32'd11};
        send_vector(0, 1'b0, 1'b0, "rst_mid");
        async_reset(0, "rst_mid");

        vq = '{32'd5, 32'd7};
        send_vector(1, 1'b1, 1'b1, "rst_hold");
        async_reset(1, "rst_hold");

        vq = '{32'd4};
        exp_q.push_back(pk(32'd4, 32'd4, 32'd0, 16'd1, 1'b0));
        send_vector(0, 1'b1, 1'b1, "post_rst");
        recv(0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
